// File: rtl/prod_bcd_conv.sv
// prod_bcd_conv
// Converts an unsigned binary product into packed BCD using the shift-and-add-3
// (double dabble) algorithm. One bit is shifted per clock, so a conversion
// takes IN_W cycles, plus one DONE cycle and one return-to-IDLE cycle.
//
// Parameters:
//   IN_W    binary input width (default 8)
//   DIGITS  BCD digits produced; 10**DIGITS must exceed 2**IN_W-1 (default 3)
//
// Ports:
//   clk        rising-edge clock
//   n_rst      asynchronous active-low reset
//   in_valid   product is present on 'product'
//   in_ready   block is idle and will capture on in_valid
//   product    unsigned binary value to convert
//   out_valid  bcd holds a completed conversion
//   out_ready  consumer takes bcd; releases the block back to IDLE
//   bcd        packed BCD result, most significant digit in the top nibble
//   bin_out    (only with PROD_BCD_BIN_OUT_EN) the captured binary product
//
// Optional feature macro: PROD_BCD_BIN_OUT_EN adds the bin_out port.

module prod_bcd_conv #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
`ifdef PROD_BCD_BIN_OUT_EN
    ,
    output logic [IN_W-1:0]       bin_out
`endif
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IN_W-1:0]    shift_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   count;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs. The handshake outputs decode
    // only the registered state, so no input reaches an output combinationally.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                // count==1 means this edge performs the last shift.
                if (count == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Add-3 correction: every digit >= 5 is bumped by 3 before the shift so
    // that doubling it carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_reg[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_reg[4*d +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: capture in IDLE, shift {bcd, shift} in SHIFT,
    // hold in DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= product;
                        bcd_reg   <= '0;
                        count     <= CNT_W'(IN_W);
                    end
                end
                SHIFT: begin
                    bcd_reg   <= {bcd_adj[BCD_W-2:0], shift_reg[IN_W-1]};
                    shift_reg <= {shift_reg[IN_W-2:0], 1'b0};
                    count     <= count - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd = bcd_reg;

`ifdef PROD_BCD_BIN_OUT_EN
    // Copy of the captured product, held alongside the BCD result.
    logic [IN_W-1:0] bin_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bin_reg <= '0;
        end else if (state == IDLE && in_valid) begin
            bin_reg <= product;
        end
    end

    assign bin_out = bin_reg;
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// tb_prod_bcd_conv
// Directed bench for prod_bcd_conv with hand-computed BCD results.
// Define PROD_BCD_BIN_OUT_EN for both files to also exercise bin_out.

module tb_prod_bcd_conv;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  product;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
`ifdef PROD_BCD_BIN_OUT_EN
    logic [7:0]  bin_out;
`endif

    int tests_run;
    int tests_failed;

    prod_bcd_conv #(.IN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd)
`ifdef PROD_BCD_BIN_OUT_EN
        ,
        .bin_out   (bin_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present a product for exactly one accepting edge; returns 1ns after it.
    task automatic applyStimulus(input logic [7:0] value);
        product  = value;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full conversion with out_ready held high: checks latency, result and
    // the single-edge return to IDLE.
    task automatic runConversion(input logic [7:0] value, input logic [11:0] expected,
                                 input string tag);
        out_ready = 1'b1;
        applyStimulus(value);
        checkOutput({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        checkOutput({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_bcd"}, {20'd0, bcd}, {20'd0, expected});
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic seen_valid;
        tests_run    = 0;
        tests_failed = 0;
        n_rst        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        product      = 8'd0;

        // Reset state.
        #12;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_bcd", {20'd0, bcd}, 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic conversions, including zero and the maximum input.
        runConversion(8'd0,   12'h000, "p0");
        runConversion(8'd225, 12'h225, "p225");
        runConversion(8'd255, 12'h255, "p255");
        runConversion(8'd100, 12'h100, "p100");
        runConversion(8'd99,  12'h099, "p99");

        // Back-pressure in DONE: result and in_ready held until out_ready.
        out_ready = 1'b0;
        applyStimulus(8'd57);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_bcd", {20'd0, bcd}, 32'h057);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_bcd", {20'd0, bcd}, 32'h057);
            checkOutput("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_drop", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // in_valid held with product changing during SHIFT is ignored.
        product  = 8'd42;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            product = 8'(i * 31 + 5);
            @(posedge clk);
            #1;
        end
        product = 8'd250;
        @(posedge clk);
        #1;
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_bcd", {20'd0, bcd}, 32'h042);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hold_idle", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of a conversion discards it.
        applyStimulus(8'd200);
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        checkOutput("abort_bcd", {20'd0, bcd}, 32'd0);
        checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        n_rst      = 1'b1;
        seen_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("abort_no_pulse", {31'd0, seen_valid}, 32'd0);
        runConversion(8'd200, 12'h200, "p200");

`ifdef PROD_BCD_BIN_OUT_EN
        out_ready = 1'b0;
        applyStimulus(8'd173);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bin_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bin_bcd", {20'd0, bcd}, 32'h173);
        checkOutput("bin_out", {24'd0, bin_out}, 32'd173);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
